// File: rtl/alu_pkg.sv
// Shared constants, opcode codes and loader state encoding for the byte-serial
// ALU operand loader.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int F_W    = 12;
    localparam int OP_W   = 4;

    // Opcode n selects ALU function bit n; codes above OP_PASSB are illegal.
    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd2;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND   = 4'd4;
    localparam logic [OP_W-1:0] OP_OR    = 4'd5;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd10;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd11;

    // Beat index carrying the opcode; beats 0-3 are A, 4-7 are B.
    localparam logic [3:0] BEAT_OP = 4'd8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 4-bit opcode to one-hot ALU function select,
// plus a flag for the unassigned codes.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic [F_W-1:0]  onehot_o,
    output logic            illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        onehot_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU,
            OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_PASSB: onehot_o = F_W'(1) << op_i;
            default:                          illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_operand_loader.sv
// Byte-serial front end for the 32-bit one-hot ALU: 9-beat frame (A, B, opcode)
// in, registered ALU drive, captured result out. ALU_LOADER_ERR_EN adds res_err.
module alu_operand_loader
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [F_W-1:0]    alu_f,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready
`ifdef ALU_LOADER_ERR_EN
    ,
    output logic              res_err
`endif
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [F_W-1:0]    alu_f_q, alu_f_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
`ifdef ALU_LOADER_ERR_EN
    logic              illegal_q, illegal_d;
    logic              res_err_q, res_err_d;
`endif

    logic [F_W-1:0]    dec_onehot;
    logic              dec_illegal;
    logic [4:0]        lane_lsb;

    alu_op_decode u_op_decode (
        .op_i      (in_data[OP_W-1:0]),
        .onehot_o  (dec_onehot),
        .illegal_o (dec_illegal)
    );

    // Byte lane within the 32-bit operand selected by the low counter bits.
    assign lane_lsb = {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_f_d    = alu_f_q;
        res_data_d = res_data_q;
`ifdef ALU_LOADER_ERR_EN
        illegal_d  = illegal_q;
        res_err_d  = res_err_q;
`endif
        if (clr) begin
            // Abort: operands and function stay on the ALU, only sequencing restarts.
            state_d = LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt_q == BEAT_OP) begin
                            // Illegal codes already decode to zero; the guard keeps that explicit.
                            alu_f_d = dec_illegal ? '0 : dec_onehot;
`ifdef ALU_LOADER_ERR_EN
                            illegal_d = dec_illegal;
`endif
                            cnt_d   = '0;
                            state_d = EXEC;
                        end else begin
                            if (cnt_q[2]) begin
                                alu_b_d[lane_lsb +: 8] = in_data;
                            end else begin
                                alu_a_d[lane_lsb +: 8] = in_data;
                            end
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                EXEC: begin
                    res_data_d = alu_y;
`ifdef ALU_LOADER_ERR_EN
                    res_err_d  = illegal_q;
`endif
                    state_d    = DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: all loader state, including the wide operand and result registers, is reset so a mid-frame rstn discards everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_f_q    <= '0;
            res_data_q <= '0;
`ifdef ALU_LOADER_ERR_EN
            illegal_q  <= 1'b0;
            res_err_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_f_q    <= alu_f_d;
            res_data_q <= res_data_d;
`ifdef ALU_LOADER_ERR_EN
            illegal_q  <= illegal_d;
            res_err_q  <= res_err_d;
`endif
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == LOAD);
    assign res_valid = (state_q == DONE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign res_data  = res_data_q;
`ifdef ALU_LOADER_ERR_EN
    assign res_err   = res_err_q;
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: behavioural ALU on the a/b/f bus,
// scoreboard queue of expected results checked as each frame completes.
module tb_alu_operand_loader;
    import alu_pkg::*;

    logic              clk;
    logic              rstn;
    logic              clr;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [F_W-1:0]    alu_f;
    logic [DATA_W-1:0] alu_y;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
`ifdef ALU_LOADER_ERR_EN
    logic              res_err;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        logic [F_W-1:0]    f;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_operand_loader dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
`ifdef ALU_LOADER_ERR_EN
        ,
        .res_err   (res_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? '1 : '0;
            4'd3:    return (a < b) ? '1 : '0;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return $unsigned($signed(a) >>> b[4:0]);
            4'd11:   return b;
            default: return '0;
        endcase
    endfunction

    // External ALU: anything other than a single function bit yields zero.
    always_comb begin
        alu_y = '0;
        for (int i = 0; i < F_W; i++) begin
            if (alu_f == (F_W'(1) << i)) alu_y = ref_alu(alu_a, alu_b, 4'(i));
        end
    end

    task automatic send_beat(input logic [7:0] d);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 40) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, budget);
        end
    endtask

    // Drives a full frame and pushes its expected result; returns at the
    // falling edge right after the opcode beat was accepted.
    task automatic send_frame(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [3:0] op);
        exp_t e;
        for (int i = 0; i < 4; i++) send_beat(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_beat(b[8*i +: 8]);
        send_beat({4'($urandom), op});
        e.data = ref_alu(a, b, op);
        e.err  = (op > 4'd11);
        e.f    = (op > 4'd11) ? '0 : (F_W'(1) << op);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called in the EXEC cycle; checks EXEC outputs, result latency, data,
    // optional backpressure for 'hold' cycles, then completes the handshake.
    task automatic collect(input string name, input int hold);
        exp_t e;
        total++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_exec_hs: in_ready=%0b res_valid=%0b, required 0 0", name, in_ready, res_valid);
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_queue: scoreboard empty, required one entry", name);
            return;
        end
        e = exp_q.pop_front();
        total++;
        if (alu_f !== e.f) begin
            bad++;
            $display("FAIL %s_alu_f: got %03h, required %03h", name, alu_f, e.f);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_latency: res_valid=%0b, required 1", name, res_valid);
        end
        total++;
        if (res_data !== e.data) begin
            bad++;
            $display("FAIL %s_data: got %08h, required %08h", name, res_data, e.data);
        end
`ifdef ALU_LOADER_ERR_EN
        total++;
        if (res_err !== e.err) begin
            bad++;
            $display("FAIL %s_err: got %0b, required %0b", name, res_err, e.err);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            total++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== e.data) begin
                bad++;
                $display("FAIL %s_backpressure: res_valid=%0b in_ready=%0b data=%08h, required 1 0 %08h",
                         name, res_valid, in_ready, res_data, e.data);
            end
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_release: res_valid=%0b in_ready=%0b, required 0 1", name, res_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%0b res_valid=%0b, required 1 0", in_ready, res_valid);
        end
        total++;
        if (alu_a !== '0 || alu_b !== '0 || alu_f !== '0 || res_data !== '0) begin
            bad++;
            $display("FAIL reset_regs: a=%08h b=%08h f=%03h res=%08h, required all 0", alu_a, alu_b, alu_f, res_data);
        end
`ifdef ALU_LOADER_ERR_EN
        total++;
        if (res_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %0b, required 0", res_err);
        end
`endif
    endtask

    task automatic test_add();
        send_frame(32'h0000_0005, 32'h0000_0003, OP_ADD);
        collect("add", 0);
    endtask

    task automatic test_compare();
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT);
        collect("slt", 0);
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU);
        collect("sltu", 0);
    endtask

    task automatic test_sra();
        send_frame(32'h8000_0000, 32'h0000_0004, OP_SRA);
        total++;
        if (alu_f !== 12'h400) begin
            bad++;
            $display("FAIL sra_exec_f: got %03h, required 400", alu_f);
        end
        collect("sra", 0);
    endtask

    task automatic test_backpressure();
        send_frame(32'hDEAD_BEEF, 32'h0000_1111, OP_XOR);
        collect("bp", 3);
        // A consumed stray byte would shift this frame's lanes.
        send_frame(32'h0000_0010, 32'h0000_0020, OP_SUB);
        collect("bp_next", 0);
    endtask

    task automatic test_abort();
        send_beat(8'hA1); send_beat(8'hB2); send_beat(8'hC3); send_beat(8'hD4); send_beat(8'hE5);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== 32'hD4C3_B2A1) begin
            bad++;
            $display("FAIL abort_state: in_ready=%0b res_valid=%0b a=%08h, required 1 0 d4c3b2a1",
                     in_ready, res_valid, alu_a);
        end
        send_frame(32'h1234_5678, 32'h0000_0001, OP_SLL);
        collect("abort_sll", 0);
    endtask

    task automatic test_clr_done();
        exp_t e;
        send_frame(32'h0000_00F0, 32'h0000_000F, OP_OR);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (res_valid !== 1'b1 || res_data !== e.data) begin
            bad++;
            $display("FAIL clr_done_result: res_valid=%0b data=%08h, required 1 %08h", res_valid, res_data, e.data);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_done_abort: res_valid=%0b in_ready=%0b, required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        send_frame(32'($urandom), 32'($urandom), 4'd13);
        collect("illegal", 0);
        send_frame(32'h0000_0007, 32'h0000_0009, OP_AND);
        collect("after_illegal", 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send_frame(32'($urandom), 32'($urandom), 4'($urandom_range(0, 11)));
            collect("b2b", 0);
        end
    endtask

    task automatic test_reset_mid();
        send_beat(8'h11); send_beat(8'h22); send_beat(8'h33);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        total++;
        if (alu_a !== '0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: a=%08h in_ready=%0b res_valid=%0b, required 0 1 0", alu_a, in_ready, res_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        send_frame(32'h0000_0100, 32'h0000_0002, OP_SRL);
        collect("post_reset", 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_compare();
        test_sra();
        test_backpressure();
        test_abort();
        test_clr_done();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
